// File: rtl/cache_controller.sv
// 4-way set-associative cache controller: tag/valid/dirty/PLRU state,
// dirty write-back and line refill over a req/ready RAM port.
module cache_controller #(
    parameter int bitsDirect  = 10,
    parameter int sizeBitLine = 64,
    parameter int ADDR_W      = 20
) (
    input  logic                   clk,
    input  logic                   gen_reset,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [1:0]             cpu_wmask,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [sizeBitLine-1:0] cpu_wdata,
    output logic                   cpu_ready,
    output logic [sizeBitLine-1:0] cpu_rdata,
    output logic [3:0]             c_write_enable,
    output logic [1:0]             c_write_enable_cpu,
    output logic                   c_write_enable_ram,
    output logic                   c_read_enable,
    output logic [bitsDirect-1:0]  c_adress,
    output logic [sizeBitLine-1:0] c_data_in,
    input  logic [sizeBitLine-1:0] c_data_out1,
    input  logic [sizeBitLine-1:0] c_data_out2,
    input  logic [sizeBitLine-1:0] c_data_out3,
    input  logic [sizeBitLine-1:0] c_data_out4,
    output logic                   ram_req,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [sizeBitLine-1:0] ram_wdata,
    input  logic [sizeBitLine-1:0] ram_rdata,
    input  logic                   ram_ready
);
    localparam int TAG_W = ADDR_W - bitsDirect;
    localparam int SETS  = 1 << bitsDirect;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, RESPOND, WB_RD, WB, REFILL, FILL
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0]      addr_q;
    logic                   we_q;
    logic [1:0]             wmask_q;
    logic [sizeBitLine-1:0] wdata_q;
    logic [1:0]             way_q;
    logic [TAG_W-1:0]       vtag_q;
    logic [sizeBitLine-1:0] wb_q;
    logic                   wb_cap;
    logic [sizeBitLine-1:0] fill_q;
    logic [sizeBitLine-1:0] rdata_q;

    logic [TAG_W-1:0]       tag_mem [4][SETS];
    logic [3:0][SETS-1:0]   valid_q;
    logic [3:0][SETS-1:0]   dirty_q;
    logic [SETS-1:0][2:0]   plru_q;

    logic [bitsDirect-1:0]  idx;
    logic [TAG_W-1:0]       tag;
    logic [3:0]             hit_vec;
    logic                   hit;
    logic [1:0]             hit_way;
    logic [1:0]             victim;
    logic [2:0]             plru;
    logic [sizeBitLine-1:0] dout [4];
    logic [sizeBitLine-1:0] dsel;

    assign idx     = addr_q[bitsDirect-1:0];
    assign tag     = addr_q[ADDR_W-1:bitsDirect];
    assign plru    = plru_q[idx];
    assign dout[0] = c_data_out1;
    assign dout[1] = c_data_out2;
    assign dout[2] = c_data_out3;
    assign dout[3] = c_data_out4;
    assign dsel    = dout[way_q];

    // plru = {b0, b1, b2}
    function automatic logic [2:0] plru_upd(input logic [2:0] p,
                                            input logic [1:0] w);
        logic [2:0] r;
        r = p;
        unique case (w)
            2'd0: r = {1'b1, 1'b1, p[0]};
            2'd1: r = {1'b1, 1'b0, p[0]};
            2'd2: r = {1'b0, p[1], 1'b1};
            2'd3: r = {1'b0, p[1], 1'b0};
        endcase
        return r;
    endfunction

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < 4; w++) begin
            hit_vec[w] = valid_q[w][idx] && (tag_mem[w][idx] == tag);
            if (hit_vec[w]) hit_way = 2'(w);
        end
        hit = |hit_vec;
    end

    // lowest invalid way wins; otherwise follow the PLRU tree
    always_comb begin
        if (!valid_q[0][idx])      victim = 2'd0;
        else if (!valid_q[1][idx]) victim = 2'd1;
        else if (!valid_q[2][idx]) victim = 2'd2;
        else if (!valid_q[3][idx]) victim = 2'd3;
        else if (plru[2])          victim = plru[0] ? 2'd3 : 2'd2;
        else                       victim = plru[1] ? 2'd1 : 2'd0;
    end

    always_comb begin
        state_nx           = state;
        cpu_ready          = 1'b0;
        cpu_rdata          = rdata_q;
        c_write_enable     = '0;
        c_write_enable_cpu = '0;
        c_write_enable_ram = 1'b0;
        c_read_enable      = 1'b0;
        c_adress           = '0;
        c_data_in          = '0;
        ram_req            = 1'b0;
        ram_we             = 1'b0;
        ram_addr           = '0;
        ram_wdata          = '0;
        unique case (state)
            IDLE: if (cpu_req) state_nx = LOOKUP;
            LOOKUP: begin
                c_read_enable = 1'b1;
                c_adress      = idx;
                if (hit) begin
                    state_nx = RESPOND;
                    if (we_q) begin
                        c_write_enable     = 4'b0001 << hit_way;
                        c_write_enable_cpu = wmask_q;
                        c_data_in          = wdata_q;
                    end
                end else if (valid_q[victim][idx] && dirty_q[victim][idx]) begin
                    state_nx = WB_RD;
                end else begin
                    state_nx = REFILL;
                end
            end
            RESPOND: begin
                cpu_ready = 1'b1;
                if (!we_q) cpu_rdata = dsel;
                state_nx = IDLE;
            end
            WB_RD: begin
                c_read_enable = 1'b1;
                c_adress      = idx;
                state_nx      = WB;
            end
            WB: begin
                ram_req   = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = {vtag_q, idx};
                ram_wdata = wb_cap ? dsel : wb_q;
                if (ram_ready) state_nx = REFILL;
            end
            REFILL: begin
                ram_req  = 1'b1;
                ram_addr = addr_q;
                if (ram_ready) state_nx = FILL;
            end
            FILL: begin
                c_write_enable     = 4'b0001 << way_q;
                c_write_enable_ram = 1'b1;
                c_adress           = idx;
                c_data_in          = fill_q;
                state_nx           = LOOKUP;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (gen_reset) begin
            state   <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            plru_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wmask_q <= '0;
            wdata_q <= '0;
            way_q   <= '0;
            vtag_q  <= '0;
            wb_q    <= '0;
            wb_cap  <= 1'b0;
            fill_q  <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: if (cpu_req) begin
                    addr_q  <= cpu_addr;
                    we_q    <= cpu_we;
                    wmask_q <= cpu_wmask;
                    wdata_q <= cpu_wdata;
                end
                LOOKUP: begin
                    if (hit) begin
                        way_q <= hit_way;
                        if (we_q) dirty_q[hit_way][idx] <= 1'b1;
                    end else begin
                        way_q  <= victim;
                        vtag_q <= tag_mem[victim][idx];
                        wb_cap <= 1'b1;
                    end
                end
                RESPOND: begin
                    plru_q[idx] <= plru_upd(plru, way_q);
                    if (!we_q) rdata_q <= dsel;
                end
                WB: begin
                    if (wb_cap) begin
                        wb_q   <= dsel;
                        wb_cap <= 1'b0;
                    end
                    if (ram_ready) dirty_q[way_q][idx] <= 1'b0;
                end
                REFILL: if (ram_ready) fill_q <= ram_rdata;
                FILL: begin
                    valid_q[way_q][idx] <= 1'b1;
                    dirty_q[way_q][idx] <= 1'b0;
                    plru_q[idx]         <= plru_upd(plru, way_q);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!gen_reset && state == FILL) tag_mem[way_q][idx] <= tag;
    end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- 4-way set-associative controller that drives the 4-block cache data array (write_enable[3:0], write_enable_cpu, write_enable_ram, read_enable, adress, data_in, data_out1..4).
- Serves one CPU request at a time. Holds tag/valid/dirty/PLRU state internally.
- Handles misses with write-back of dirty victims and line refill over a req/ready RAM interface. Sits between CPU and RAM; the data array is its only storage for line data.

Parameters:
- bitsDirect, 10, set index width; one line per set per way.
- sizeBitLine, 64, line width in bits.
- ADDR_W, 20, CPU/RAM line-address width; tag = ADDR_W-bitsDirect bits.

Ports:
- clk  in  1  clock
- gen_reset  in  1  synchronous active-high reset
- cpu_req  in  1  request; sampled only in IDLE
- cpu_we  in  1  1=write, 0=read
- cpu_wmask  in  2  word select for writes: 01 low half, 10 high half, 11 full line
- cpu_addr  in  ADDR_W  line address; index=[bitsDirect-1:0], tag=upper bits
- cpu_wdata  in  sizeBitLine  write data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  sizeBitLine  read data, valid when cpu_ready=1, held until next completion
- c_write_enable  out  4  per-way write strobe to array
- c_write_enable_cpu  out  2  CPU write word mask to array
- c_write_enable_ram  out  1  full-line refill write to array
- c_read_enable  out  1  array read strobe
- c_adress  out  bitsDirect  array set index
- c_data_in  out  sizeBitLine  array write data
- c_data_out1..c_data_out4  in  sizeBitLine each  array way outputs, valid 1 cycle after c_read_enable
- ram_req  out  1  RAM request, held until ram_ready
- ram_we  out  1  1=line write-back, 0=line fetch
- ram_addr  out  ADDR_W  line address
- ram_wdata  out  sizeBitLine  write-back data
- ram_rdata  in  sizeBitLine  fetch data, valid with ram_ready
- ram_ready  in  1  one-cycle completion of the current RAM request

Behaviour:
- Reset, at a clock edge with gen_reset=1: state=IDLE; all valid, dirty and PLRU bits cleared; all outputs 0. This applies in any state. An in-flight RAM transaction is abandoned (ram_req=0 the following cycle) and the CPU request is dropped with no cpu_ready.
- IDLE: when cpu_req=1, latch addr/we/wmask/wdata, go LOOKUP. Requests arriving in any other state are ignored.
- LOOKUP: c_read_enable=1, c_adress=index. Tag compare against the 4 ways (valid required); at most one way hits by construction.
  - Read hit: go RESPOND.
  - Write hit: same cycle c_write_enable=onehot(way), c_write_enable_cpu=wmask, c_data_in=wdata; set dirty; go RESPOND.
  - Miss: victim = lowest-index invalid way, else PLRU victim. Go WB_RD if victim is valid and dirty, else REFILL.
- RESPOND:
  - For a read, cpu_rdata=c_data_out of the hit way.
  - cpu_ready=1 for exactly 1 cycle; update PLRU for that way; go IDLE.
  - Read/write hit latency: cpu_req sampled at cycle N, cpu_ready at N+2.
- WB_RD: c_read_enable=1 on the victim set; next cycle capture the victim data into ram_wdata; go WB.
- WB: ram_req=1, ram_we=1, ram_addr={victim tag,index}, all stable until the ram_ready cycle; then clear dirty, go REFILL.
- REFILL: ram_req=1, ram_we=0, ram_addr=latched cpu_addr, until ram_ready; capture ram_rdata; go FILL.
- FILL (1 cycle):
  - c_write_enable=onehot(victim), c_write_enable_ram=1, c_write_enable_cpu=00, c_data_in=captured data.
  - Set tag, valid=1, dirty=0; update PLRU; go LOOKUP (replay, which then hits).
- ram_req deasserts in the cycle after ram_ready. ram_ready is ignored when ram_req=0.
- PLRU per set, 3 bits {b0,b1,b2}:
  - Victim selection: b0=0 selects ways 0/1 (b1=0 gives way0, else way1); b0=1 selects ways 2/3 (b2=0 gives way2, else way3).
  - On access: way0 sets b0=1,b1=1; way1 sets b0=1,b1=0; way2 sets b0=0,b2=1; way3 sets b0=0,b2=0.
- Outside the listed states, all array strobes are 0.

Test Plan:
- Reset, then read 0x00005 (miss): ram_req with ram_we=0, ram_addr=0x00005; ram_ready 3 cycles later with 64'hDEADBEEF_CAFEF00D → FILL writes way0, c_write_enable=0001 with c_write_enable_ram=1, then cpu_ready with that data. Repeat the read → cpu_ready exactly 2 cycles after cpu_req, no ram_req.
- Write 0x00005, wmask=01, wdata=64'h0000_0000_1234_5678 → in LOOKUP c_write_enable=0001, c_write_enable_cpu=01; cpu_ready at N+2; no RAM traffic.
- Read 0x00405, 0x00805, 0x00C05 (fill ways 1-3), then read 0x01005 → PLRU victim way0, dirty: WB with ram_we=1, ram_addr=0x00005 and the merged data, then REFILL ram_addr=0x01005; a subsequent read of 0x00005 misses.
- Hold ram_ready low 10 cycles during REFILL → ram_req, ram_addr, ram_we stable for all 10 cycles; no cpu_ready; cpu_req toggling during the wait is ignored.
- Assert gen_reset during REFILL → ram_req=0 and cpu_ready=0 next cycle; a read of any previously filled address then misses.
- Back-to-back hit reads to 0x00405 and 0x00805 with cpu_req held high → two cpu_ready pulses 3 cycles apart, correct data each.
